// File: rtl/multicycle_shifter_of_n_pkg.sv
// Shared types for the iterative shifter: operation encoding and FSM states.
package multicycle_shifter_of_n_pkg;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ROR = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/multicycle_shifter_of_n_step.sv
// One combinational shift/rotate step of k bits (k never exceeds STEP).
module shift_step_of_n
  import multicycle_shifter_of_n_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  shift_op_t     op,
  input  logic [AW-1:0] k,
  output logic [N-1:0]  shifted
);

  // Select the shifted value for the requested operation
  always_comb begin
    shifted = data;
    case (op)
      SLL:     shifted = data << k;
      SRL:     shifted = data >> k;
      SRA:     shifted = $unsigned($signed(data) >>> k);
      ROR:     shifted = (data >> k) | (data << (N - int'(k)));
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/multicycle_shifter_of_n.sv
// Iterative shifter: accepts an operand, then shifts at most STEP bits per clock
// until the amount is consumed; valid/ready handshakes on both sides.
module multicycle_shifter_of_n
  import multicycle_shifter_of_n_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int AW   = $clog2(N)  // derived from N; leave at default
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  state_t        state_r;
  shift_op_t     op_r;
  logic [N-1:0]  data_r;
  logic [AW-1:0] amt_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic [AW-1:0] k_s;
  logic [N-1:0]  step_s;

  // Clip this clock's step to what is still remaining, so the last step never over-shifts
  always_comb begin
    if (amt_r > AW'(STEP)) begin
      k_s = AW'(STEP);
    end else begin
      k_s = amt_r;
    end
  end

  shift_step_of_n #(.N(N), .AW(AW)) u_step (
    .data    (data_r),
    .op      (op_r),
    .k       (k_s),
    .shifted (step_s)
  );

  // Control FSM and datapath registers; DONE spends one cycle settling before out_valid rises
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= SLL;
      data_r      <= '0;
      amt_r       <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r     <= in_data;
            amt_r      <= in_amt;
            op_r       <= shift_op_t'(in_op);
            in_ready_r <= 1'b0;
            if (in_amt == '0) begin
              state_r <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          data_r <= step_s;
          amt_r  <= amt_r - k_s;
          if (amt_r == k_s) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_valid_r && out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_multicycle_shifter_of_n.sv
// Self-checking bench: three shifter instances (8/1, 8/3, 16/4) driven one at a time,
// results and output timing checked against a queue of expected values.
module tb_multicycle_shifter_of_n;
  import multicycle_shifter_of_n_pkg::*;

  typedef struct {
    logic [15:0] data;
    int          rise;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid_v = 3'b000;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_amt = 4'h0;
  logic [1:0]  in_op = 2'd0;
  logic        out_ready = 1'b0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [7:0]  od0, od1;
  logic [15:0] od2;
  int          sel = 0;
  logic        obs_ready, obs_valid;
  logic [15:0] obs_data;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_shifter_of_n #(.N(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .in_data(in_data[7:0]), .in_amt(in_amt[2:0]), .in_op(in_op),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0));

  multicycle_shifter_of_n #(.N(8), .STEP(3)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .in_data(in_data[7:0]), .in_amt(in_amt[2:0]), .in_op(in_op),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1));

  multicycle_shifter_of_n #(.N(16), .STEP(4)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2));

  always_comb begin
    obs_ready = ir0;
    obs_valid = ov0;
    obs_data  = {8'h00, od0};
    case (sel)
      1: begin obs_ready = ir1; obs_valid = ov1; obs_data = {8'h00, od1}; end
      2: begin obs_ready = ir2; obs_valid = ov2; obs_data = od2; end
      default: begin obs_ready = ir0; obs_valid = ov0; obs_data = {8'h00, od0}; end
    endcase
  end

  // Reference single-shot shift/rotate on an n-bit operand
  function automatic logic [15:0] ref_shift(input int n, input logic [15:0] d,
                                            input int amt, input logic [1:0] op);
    logic [31:0] m, x, r;
    m = (32'd1 << n) - 32'd1;
    x = {16'h0, d} & m;
    case (op)
      2'd0:    r = (x << amt) & m;
      2'd1:    r = x >> amt;
      2'd2:    r = (x >> amt) | (x[n-1] ? (m & ~(m >> amt)) : 32'd0);
      default: r = ((x >> amt) | (x << (n - amt))) & m;
    endcase
    return r[15:0];
  endfunction

  task automatic run_op(input int s, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] op, input logic [15:0] expv, input int hold);
    int st, e, waited;
    exp_t x;
    st = (s == 0) ? 1 : ((s == 1) ? 3 : 4);
    sel = s;
    waited = 0;
    @(negedge clk);
    while (!obs_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b required 1", obs_ready);
      return;
    end
    in_data = d;
    in_amt = a;
    in_op = op;
    in_valid_v[s] = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    x.data = expv;
    x.rise = e + 1 + (int'(a) + st - 1) / st;
    q.push_back(x);
    in_valid_v[s] = 1'b0;
    in_data = 16'($urandom);
    in_amt = 4'($urandom);
    in_op = 2'($urandom);
    waited = 0;
    @(negedge clk);
    while (!obs_valid && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: out_valid=%b required 1", obs_valid);
      x = q.pop_front();
      return;
    end
    checks++;
    if (cyc !== q[0].rise) begin
      errors++;
      $display("FAIL latency: out_valid rose at edge %0d required %0d", cyc, q[0].rise);
    end
    repeat (hold) begin
      checks++;
      if (obs_data !== q[0].data || obs_valid !== 1'b1 || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: data=%h valid=%b ready=%b required data=%h valid=1 ready=0",
                 obs_data, obs_valid, obs_ready, q[0].data);
      end
      in_valid_v[s] = ~in_valid_v[s];
      @(negedge clk);
    end
    in_valid_v[s] = 1'b0;
    out_ready = 1'b1;
    x = q.pop_front();
    checks++;
    if (obs_data !== x.data) begin
      errors++;
      $display("FAIL result: out_data=%h required %h (sel=%0d d=%h amt=%0d op=%0d)",
               obs_data, x.data, s, d, a, op);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_state: ready=%b valid=%b data=%h required 1 0 0000",
                 obs_ready, obs_valid, obs_data);
      end
    end
  endtask

  task automatic test_step1();
    run_op(0, 16'h00B3, 4'd3, SLL, 16'h0098, 0);
    run_op(0, 16'h0096, 4'd2, SRA, 16'h00E5, 1);
    run_op(0, 16'h0081, 4'd1, ROR, 16'h00C0, 0);
    run_op(0, 16'h0080, 4'd7, SRA, 16'h00FF, 0);
  endtask

  task automatic test_step3();
    run_op(1, 16'h00F0, 4'd7, SRL, 16'h0001, 0);
    run_op(1, 16'h005A, 4'd0, SLL, 16'h005A, 0);
    run_op(1, 16'h0096, 4'd5, ROR, 16'h00B4, 2);
  endtask

  task automatic test_back_pressure();
    run_op(0, 16'h00C3, 4'd2, SRL, 16'h0030, 5);
    @(negedge clk);
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_release: ready=%b valid=%b required 1 0", obs_ready, obs_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    sel = 0;
    @(negedge clk);
    in_data = 16'h00A5;
    in_amt = 4'd7;
    in_op = SLL;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_valid !== 1'b0 || obs_data !== 16'h0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h ready=%b required 0 0000 1",
               obs_valid, obs_data, obs_ready);
    end
    run_op(0, 16'h0001, 4'd1, SLL, 16'h0002, 0);
  endtask

  task automatic test_soak();
    logic [15:0] d;
    logic [3:0]  a;
    logic [1:0]  op;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      a = 4'($urandom);
      op = 2'($urandom);
      run_op(2, d, a, op, ref_shift(16, d, int'(a), op), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_step1();
    test_step3();
    test_back_pressure();
    test_reset_mid_op();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
